// File: rtl/gh18b20_pkg.sv
// Shared constants and types for the gh18b20 1-Wire temperature-sensor slave.
package gh18b20_pkg;

  localparam logic [7:0] CMD_SKIP_ROM = 8'hCC;
  localparam logic [7:0] CMD_CONVERT  = 8'h44;
  localparam logic [7:0] CMD_READ_SP  = 8'hBE;

  localparam logic [7:0] SP_TH   = 8'h4B;
  localparam logic [7:0] SP_TL   = 8'h46;
  localparam logic [7:0] SP_CFG  = 8'h7F;
  localparam logic [7:0] SP_RES0 = 8'hFF;
  localparam logic [7:0] SP_RES1 = 8'h0C;
  localparam logic [7:0] SP_RES2 = 8'h10;

  localparam int SP_BITS = 72;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRES_WAIT,
    ST_PRESENCE,
    ST_ROM_CMD,
    ST_FUNC_CMD,
    ST_READ
  } state_t;

  // Scratchpad bytes 0-7; bit 0 is the first bit on the wire.
  function automatic logic [63:0] sp_body(input logic [15:0] temp);
    return {SP_RES2, SP_RES1, SP_RES0, SP_CFG, SP_TL, SP_TH, temp};
  endfunction

endpackage

// File: rtl/gh18b20_crc8.sv
// Bit-serial Dallas CRC-8 (reflected poly 0x8C, init 0x00) over a 64-bit word, LSB first.
module gh18b20_crc8 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] data,
  output logic [7:0]  crc
);

  logic [63:0] sh;
  logic [6:0]  cnt;
  logic [7:0]  acc;
  logic [7:0]  acc_nxt;

  assign acc_nxt = {1'b0, acc[7:1]} ^ ((acc[0] ^ sh[0]) ? 8'h8C : 8'h00);

  always_ff @(posedge clk) begin
    if (start) sh <= data;
    else       sh <= {1'b0, sh[63:1]};
  end

  // crc only changes once the whole word has been folded in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      acc <= '0;
      crc <= '0;
    end else if (start) begin
      cnt <= 7'd64;
      acc <= '0;
    end else if (cnt != 7'd0) begin
      acc <= acc_nxt;
      cnt <= cnt - 7'd1;
      if (cnt == 7'd1) crc <= acc_nxt;
    end
  end

endmodule

// File: rtl/gh18b20_slave.sv
// DS18B20-style 1-Wire slave (SKIP ROM, CONVERT T, READ SCRATCHPAD) on open-drain dq.
// Define GH18B20_CRC_EN to serve a Dallas CRC-8 in scratchpad byte 8 instead of 0xFF.
module gh18b20_slave
  import gh18b20_pkg::*;
#(
  parameter int          CLK_PER_US   = 50,
  parameter int          RST_MIN_US   = 400,
  parameter int          PRES_WAIT_US = 30,
  parameter int          PRES_US      = 120,
  parameter int          SAMPLE_US    = 30,
  parameter int          RDRV_US      = 45,
  parameter int          CONV_US      = 100,
  parameter logic [15:0] POR_TEMP     = 16'h0550
) (
  input  logic        clk,
  input  logic        rst_n,
  inout  wire         dq,
  input  logic [15:0] temp_i,
  output logic        conv_busy_o
);

  localparam logic [15:0] PS_LIM   = 16'(CLK_PER_US - 1);
  localparam logic [15:0] RST_LIM  = 16'(RST_MIN_US);
  localparam logic [15:0] PW_LIM   = 16'(PRES_WAIT_US - 1);
  localparam logic [15:0] PR_LIM   = 16'(PRES_US - 1);
  localparam logic [15:0] SMP_LIM  = 16'(SAMPLE_US - 1);
  localparam logic [15:0] RD_LIM   = 16'(RDRV_US - 1);
  localparam logic [15:0] CONV_LIM = 16'(CONV_US - 1);

  state_t             state, state_nxt;
  logic               dq_p0, dq_p1, dq_p2;
  logic               fall, rise;
  logic [15:0]        ps_cnt;
  logic               us_tick;
  logic [15:0]        low_us;
  logic               reset_det;
  logic [15:0]        tmr, tmr_lim;
  logic               tmr_run, tmr_done;
  logic [2:0]         bit_cnt;
  logic [7:0]         shreg;
  logic [7:0]         rx_byte;
  logic               rx_en, byte_done;
  logic [6:0]         rd_idx;
  logic               drv_low;
  logic               start_conv, latch_evt;
  logic               conv_busy;
  logic [15:0]        conv_cnt;
  logic signed [15:0] temp_q;
  logic [63:0]        sp_lo;
  logic [7:0]         byte8;
  logic [71:0]        sp_vec;

  // ---- stage p0..p2: dq synchroniser and edge history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dq_p0 <= 1'b1;
      dq_p1 <= 1'b1;
      dq_p2 <= 1'b1;
    end else begin
      dq_p0 <= dq;
      dq_p1 <= dq_p0;
      dq_p2 <= dq_p1;
    end
  end

  assign fall = dq_p2 & ~dq_p1;
  assign rise = ~dq_p2 & dq_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_cnt <= '0;
      low_us <= '0;
    end else begin
      ps_cnt <= us_tick ? 16'd0 : ps_cnt + 16'd1;
      if (dq_p1)                          low_us <= '0;
      else if (us_tick && low_us != RST_LIM) low_us <= low_us + 16'd1;
    end
  end

  assign us_tick   = (ps_cnt == PS_LIM);
  assign reset_det = rise && (low_us == RST_LIM);

  always_comb begin
    case (state)
      ST_PRES_WAIT: tmr_lim = PW_LIM;
      ST_PRESENCE:  tmr_lim = PR_LIM;
      ST_READ:      tmr_lim = RD_LIM;
      default:      tmr_lim = SMP_LIM;
    endcase
  end

  assign tmr_done  = tmr_run && us_tick && (tmr == tmr_lim);
  assign rx_en     = (state == ST_ROM_CMD) || (state == ST_FUNC_CMD);
  assign rx_byte   = {dq_p1, shreg[7:1]};
  assign byte_done = rx_en && tmr_done && (bit_cnt == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // A long low followed by release wins over whatever the FSM was doing.
  always_comb begin
    state_nxt = state;
    if (reset_det) begin
      state_nxt = ST_PRES_WAIT;
    end else begin
      case (state)
        ST_PRES_WAIT: if (tmr_done) state_nxt = ST_PRESENCE;
        ST_PRESENCE:  if (tmr_done) state_nxt = ST_ROM_CMD;
        ST_ROM_CMD:
          if (byte_done) state_nxt = (rx_byte == CMD_SKIP_ROM) ? ST_FUNC_CMD : ST_IDLE;
        ST_FUNC_CMD:
          if (byte_done) state_nxt = (rx_byte == CMD_READ_SP) ? ST_READ : ST_IDLE;
        default: ;
      endcase
    end
  end

  // Slot timer, bit/byte counters and read-slot drive; all restart on a state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr     <= '0;
      tmr_run <= 1'b0;
      bit_cnt <= '0;
      rd_idx  <= '0;
      drv_low <= 1'b0;
    end else if (reset_det || (state_nxt != state)) begin
      tmr     <= '0;
      tmr_run <= (state_nxt == ST_PRES_WAIT) || (state_nxt == ST_PRESENCE);
      bit_cnt <= '0;
      rd_idx  <= '0;
      drv_low <= 1'b0;
    end else begin
      if (tmr_run && us_tick) tmr <= tmr + 16'd1;
      case (state)
        ST_ROM_CMD, ST_FUNC_CMD: begin
          if (!tmr_run && fall) begin
            tmr_run <= 1'b1;
            tmr     <= '0;
          end else if (tmr_done) begin
            tmr_run <= 1'b0;
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
        ST_READ: begin
          if (!tmr_run && fall && (rd_idx != 7'(SP_BITS))) begin
            rd_idx <= rd_idx + 7'd1;
            if (!sp_vec[rd_idx]) begin
              drv_low <= 1'b1;
              tmr_run <= 1'b1;
              tmr     <= '0;
            end
          end else if (tmr_done) begin
            drv_low <= 1'b0;
            tmr_run <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rx_en && tmr_done) shreg <= rx_byte;
  end

  // A conversion ignores 1-Wire resets; a repeated CONVERT restarts the timer.
  assign start_conv = (state == ST_FUNC_CMD) && byte_done && !reset_det &&
                      (rx_byte == CMD_CONVERT);
  assign latch_evt  = conv_busy && us_tick && (conv_cnt == CONV_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conv_busy <= 1'b0;
      conv_cnt  <= '0;
      temp_q    <= $signed(POR_TEMP);
    end else if (start_conv) begin
      conv_busy <= 1'b1;
      conv_cnt  <= '0;
    end else if (conv_busy && us_tick) begin
      if (latch_evt) begin
        conv_busy <= 1'b0;
        temp_q    <= $signed(temp_i);
      end else begin
        conv_cnt <= conv_cnt + 16'd1;
      end
    end
  end

  assign sp_lo = sp_body(temp_q);

`ifdef GH18B20_CRC_EN
  logic       crc_kick;
  logic [7:0] crc_val;

  // Comes out of reset set so the POR scratchpad also gets a valid CRC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crc_kick <= 1'b1;
    else        crc_kick <= latch_evt;
  end

  gh18b20_crc8 u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .start (crc_kick),
    .data  (sp_lo),
    .crc   (crc_val)
  );

  assign byte8 = crc_val;
`else
  assign byte8 = 8'hFF;
`endif

  assign sp_vec      = {byte8, sp_lo};
  assign conv_busy_o = conv_busy;
  assign dq          = ((state == ST_PRESENCE) || drv_low) ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_gh18b20_slave.sv
// Self-checking bench for gh18b20_slave: bus-level 1-Wire master plus a scratchpad model.
`timescale 1ns/1ps
module tb_gh18b20_slave;

  localparam int CPU = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m_low = 1'b0;
  logic [15:0] temp_i = 16'h0000;
  logic        conv_busy_o;
  wire         dq;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] m_temp = 16'h0550;

  pullup (dq);
  assign dq = m_low ? 1'b0 : 1'bz;

  always #250 clk = ~clk;

  gh18b20_slave #(.CLK_PER_US(CPU)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dq          (dq),
    .temp_i      (temp_i),
    .conv_busy_o (conv_busy_o)
  );

  function automatic logic [7:0] model_byte(input int i, input logic [15:0] t);
    logic [7:0] consts [8];
    consts = '{8'h00, 8'h00, 8'h4B, 8'h46, 8'h7F, 8'hFF, 8'h0C, 8'h10};
    if (i == 0) return t[7:0];
    if (i == 1) return t[15:8];
    return consts[i];
  endfunction

  function automatic logic [7:0] crc_bytes(input logic [7:0] b [9], input int n);
    logic [7:0] c = 8'h00;
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      d = b[i];
      for (int k = 0; k < 8; k++) begin
        c = (c[0] ^ d[0]) ? ((c >> 1) ^ 8'h8C) : (c >> 1);
        d = d >> 1;
      end
    end
    return c;
  endfunction

  task automatic wait_us(input int n);
    #(n * 1000);
  endtask

  task automatic ow_reset(output logic pres);
    m_low = 1'b1; wait_us(480); m_low = 1'b0;
    wait_us(80); pres = ~dq; wait_us(80);
  endtask

  task automatic ow_write_bit(input logic b);
    m_low = 1'b1; wait_us(b ? 2 : 60); m_low = 1'b0; wait_us(b ? 60 : 2);
  endtask

  task automatic ow_write_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) ow_write_bit(v[i]);
  endtask

  task automatic ow_read_bit(output logic b);
    m_low = 1'b1; wait_us(2); m_low = 1'b0; wait_us(13); b = dq; wait_us(35);
  endtask

  task automatic ow_read_byte(output logic [7:0] v);
    logic b;
    for (int i = 0; i < 8; i++) begin
      ow_read_bit(b);
      v[i] = b;
    end
  endtask

  task automatic read_temp(input string tag, output logic [15:0] v);
    logic p;
    logic [7:0] lo, hi;
    ow_reset(p);
    checks++;
    if (p !== 1'b1) begin errors++; $display("FAIL %s_presence: got %b expected 1", tag, p); end
    ow_write_byte(8'hCC);
    ow_write_byte(8'hBE);
    ow_read_byte(lo);
    ow_read_byte(hi);
    v = {hi, lo};
  endtask

  task automatic do_convert(input logic [15:0] t);
    logic p;
    temp_i = ~t;
    ow_reset(p);
    ow_write_byte(8'hCC);
    ow_write_byte(8'h44);
    checks++;
    if (conv_busy_o !== 1'b1) begin errors++; $display("FAIL conv_busy_start: got %b expected 1", conv_busy_o); end
    wait_us(20); temp_i = t;
    wait_us(40);
    checks++;
    if (conv_busy_o !== 1'b1) begin errors++; $display("FAIL conv_busy_mid: got %b expected 1", conv_busy_o); end
    wait_us(14);
    checks++;
    if (conv_busy_o !== 1'b0) begin errors++; $display("FAIL conv_busy_end: got %b expected 0", conv_busy_o); end
    m_temp = t;
  endtask

  task automatic test_reset();
    logic b;
    rst_n = 1'b0; wait_us(3);
    checks++;
    if (dq !== 1'b1) begin errors++; $display("FAIL reset_dq: got %b expected 1", dq); end
    checks++;
    if (conv_busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", conv_busy_o); end
    rst_n = 1'b1; wait_us(5);
    ow_write_byte(8'hCC);
    ow_read_bit(b);
    checks++;
    if (b !== 1'b1) begin errors++; $display("FAIL idle_slot: got %b expected 1", b); end
  endtask

  task automatic test_presence();
    int first = -1, last = -1;
    m_low = 1'b1; wait_us(480); m_low = 1'b0;
    for (int t = 1; t <= 200; t++) begin
      wait_us(1);
      if (dq === 1'b0) begin
        if (first < 0) first = t;
        last = t;
      end
    end
    checks++;
    if (first < 28 || first > 34) begin errors++; $display("FAIL pres_start: got %0d us expected 28..34", first); end
    checks++;
    if ((last - first + 1) < 116 || (last - first + 1) > 123) begin
      errors++; $display("FAIL pres_width: got %0d us expected 116..123", last - first + 1);
    end
  endtask

  task automatic test_por_read();
    logic [15:0] v;
    read_temp("por", v);
    checks++;
    if (v !== m_temp) begin errors++; $display("FAIL por_temp: got %h expected %h", v, m_temp); end
  endtask

  task automatic test_conversion();
    logic [15:0] v;
    do_convert(16'h0191);
    read_temp("conv", v);
    checks++;
    if (v !== m_temp) begin errors++; $display("FAIL conv_temp: got %h expected %h", v, m_temp); end
    checks++;
    if (int'(v[10:4]) != 25) begin errors++; $display("FAIL conv_degrees: got %0d expected 25", v[10:4]); end
  endtask

  task automatic test_negative_full();
    logic       p, b;
    logic [7:0] rb [9];
    do_convert(16'hFF5E);
    ow_reset(p);
    ow_write_byte(8'hCC);
    ow_write_byte(8'hBE);
    for (int i = 0; i < 9; i++) ow_read_byte(rb[i]);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rb[i] !== model_byte(i, m_temp)) begin
        errors++; $display("FAIL sp_byte%0d: got %h expected %h", i, rb[i], model_byte(i, m_temp));
      end
    end
`ifdef GH18B20_CRC_EN
    checks++;
    if (rb[8] !== crc_bytes(rb, 8)) begin errors++; $display("FAIL sp_crc: got %h expected %h", rb[8], crc_bytes(rb, 8)); end
    checks++;
    if (crc_bytes(rb, 9) !== 8'h00) begin errors++; $display("FAIL sp_crc_residue: got %h expected 00", crc_bytes(rb, 9)); end
`else
    checks++;
    if (rb[8] !== 8'hFF) begin errors++; $display("FAIL sp_byte8: got %h expected ff", rb[8]); end
`endif
    for (int i = 0; i < 2; i++) begin
      ow_read_bit(b);
      checks++;
      if (b !== 1'b1) begin errors++; $display("FAIL past_end%0d: got %b expected 1", i, b); end
    end
  endtask

  task automatic test_unknown_rom();
    logic p;
    logic [7:0] r, v;
    do r = 8'($urandom_range(0, 255)); while (r == 8'hCC);
    ow_reset(p);
    ow_write_byte(r);
    ow_read_byte(v);
    checks++;
    if (v !== 8'hFF) begin errors++; $display("FAIL unknown_rom_%h: got %h expected ff", r, v); end
  endtask

  task automatic test_unknown_func();
    logic p;
    logic [7:0] r, v;
    do r = 8'($urandom_range(0, 255)); while (r == 8'h44 || r == 8'hBE);
    ow_reset(p);
    ow_write_byte(8'hCC);
    ow_write_byte(r);
    ow_read_byte(v);
    checks++;
    if (v !== 8'hFF) begin errors++; $display("FAIL unknown_func_%h: got %h expected ff", r, v); end
    checks++;
    if (conv_busy_o !== 1'b0) begin errors++; $display("FAIL unknown_func_busy: got %b expected 0", conv_busy_o); end
  endtask

  task automatic test_abort();
    logic p;
    logic [15:0] v;
    ow_reset(p);
    ow_write_byte(8'hCC);
    for (int i = 0; i < 4; i++) ow_write_bit(1'($urandom_range(0, 1)));
    read_temp("abort", v);
    checks++;
    if (v !== m_temp) begin errors++; $display("FAIL abort_temp: got %h expected %h", v, m_temp); end
  endtask

  task automatic test_async_reset();
    logic p;
    logic [15:0] v;
    ow_reset(p);
    ow_write_byte(8'hCC);
    ow_write_byte(8'hBE);
    m_low = 1'b1; wait_us(2); m_low = 1'b0; wait_us(3);
    checks++;
    if (dq !== m_temp[0]) begin errors++; $display("FAIL async_pre_drive: got %b expected %b", dq, m_temp[0]); end
    rst_n = 1'b0;
    #20;
    checks++;
    if (dq !== 1'b1) begin errors++; $display("FAIL async_release: got %b expected 1", dq); end
    wait_us(5);
    rst_n = 1'b1;
    m_temp = 16'h0550;
    wait_us(60);
    read_temp("async", v);
    checks++;
    if (v !== m_temp) begin errors++; $display("FAIL async_temp: got %h expected %h", v, m_temp); end
  endtask

  initial begin
    test_reset();
    test_presence();
    test_por_read();
    test_conversion();
    test_negative_full();
    test_unknown_rom();
    test_unknown_func();
    test_abort();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
